stb_axi_write_master: RTL and testbench

Drains the store buffer to the AXI write port. It accepts store requests over a valid/ready interface and queues them in a small FIFO. Each entry is issued as a single-beat AXI write. Sequencing is strictly AW, then W, then B, so the write channel never shows WVALID before the AW handshake or BVALID-driven completion before WLAST. The block sits between the store buffer and the AXI fabric, and its AXI outputs feed the write-channel monitor.

---
 rtl/stb_axi_pkg.sv | 24 ++
 rtl/stb_sync_fifo.sv | 55 +++++
 rtl/stb_axi_write_master.sv | 129 ++++++++++++
 tb/tb_stb_axi_write_master.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stb_axi_pkg.sv
// Shared definitions for the store-buffer AXI write master: FSM encoding,
// BRESP codes and the error-counter ceiling.
package stb_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AW   = 2'd1,
    W    = 2'd2,
    B    = 2'd3
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // SLVERR and DECERR both carry bit 1; OKAY/EXOKAY do not.
  function automatic logic is_err_resp(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/stb_sync_fifo.sv
// Synchronous FIFO with a resident head entry: the head is readable without
// popping, so the consumer can drive it straight onto a bus.
module stb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/stb_axi_write_master.sv
// Drains queued store requests to AXI as single-beat writes, one outstanding
// transaction at a time, strictly sequenced AW -> W -> B.
module stb_axi_write_master
  import stb_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wlast,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  input  logic [1:0]              axi_bresp,
  output logic                    wr_done,
  output logic                    wr_err,
  output logic [1:0]              err_resp,
  output logic [7:0]              err_cnt,
  output logic                    idle
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PAY_W  = ADDR_WIDTH + DATA_WIDTH + STRB_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  // Every channel transfers on a rising edge where valid && ready; a valid,
  // once raised, holds itself and its payload stable until that edge.

  state_t           state;
  logic [PAY_W-1:0] head_data;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;
  assign pop       = (state == B) && axi_bvalid;

  stb_sync_fifo #(
    .WIDTH (PAY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({req_addr, req_data, req_strb}),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The head entry stays in the queue until B, so it feeds AW and W directly.
  assign {axi_awaddr, axi_wdata, axi_wstrb} = head_data;

  assign idle = (state == IDLE) && (fifo_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_wlast   <= 1'b0;
      axi_bready  <= 1'b0;
      wr_done     <= 1'b0;
      wr_err      <= 1'b0;
      err_resp    <= 2'b00;
      err_cnt     <= 8'd0;
    end else begin
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state       <= AW;
            axi_awvalid <= 1'b1;
          end
        end
        AW: begin
          if (axi_awready) begin
            state       <= W;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b1;
            axi_wlast   <= 1'b1;
          end
        end
        W: begin
          if (axi_wready) begin
            state      <= B;
            axi_wvalid <= 1'b0;
            axi_wlast  <= 1'b0;
            axi_bready <= 1'b1;
          end
        end
        B: begin
          if (axi_bvalid) begin
            state      <= IDLE;
            axi_bready <= 1'b0;
            wr_done    <= 1'b1;
            // Errored entries are popped like any other; only the log changes.
            if (is_err_resp(axi_bresp)) begin
              wr_err   <= 1'b1;
              err_resp <= axi_bresp;
              if (err_cnt != ERR_CNT_MAX) err_cnt <= err_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stb_axi_write_master.sv
// Randomized bench for stb_axi_write_master: a queue-based model of accepted
// stores, a responding AXI slave and directed timing/boundary scenarios.
module tb_stb_axi_write_master;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  req_addr = '0;
  logic [127:0] req_data = '0;
  logic [15:0]  req_strb = '0;
  logic         axi_awvalid;
  logic         axi_awready = 1'b0;
  logic [31:0]  axi_awaddr;
  logic         axi_wvalid;
  logic         axi_wready = 1'b0;
  logic [127:0] axi_wdata;
  logic [15:0]  axi_wstrb;
  logic         axi_wlast;
  logic         axi_bvalid = 1'b0;
  logic         axi_bready;
  logic [1:0]   axi_bresp = 2'b00;
  logic         wr_done;
  logic         wr_err;
  logic [1:0]   err_resp;
  logic [7:0]   err_cnt;
  logic         idle;

  always #5 clk = ~clk;

  stb_axi_write_master #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (128),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_strb    (req_strb),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_awaddr  (axi_awaddr),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wlast   (axi_wlast),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .axi_bresp   (axi_bresp),
    .wr_done     (wr_done),
    .wr_err      (wr_err),
    .err_resp    (err_resp),
    .err_cnt     (err_cnt),
    .idle        (idle)
  );

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  strb;
  } req_t;

  req_t       req_q[$];    // stores waiting to be offered
  req_t       exp_q[$];    // stores accepted and not yet completed, in order
  logic [1:0] bresp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned req_pct = 100, aw_pct = 100, w_pct = 100, b_pct = 100;
  int          bresp_mode = 0;   // 0 okay, 1 from bresp_q, 2 slverr, 3 random
  bit          junk_b = 1'b0;

  bit         aw_done, w_done, b_hold;
  logic [1:0] cur_bresp;
  bit         exp_done_nxt, exp_err_nxt;
  logic [7:0] exp_err_cnt = 8'd0;
  logic [1:0] exp_err_resp = 2'b00;
  int         done_seen = 0, err_seen = 0, acc_total = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.addr = $urandom() & 32'hFFFF_FFF0;
    r.data = {$urandom(), $urandom(), $urandom(), $urandom()};
    r.strb = 16'($urandom_range(0, 65535));
    return r;
  endfunction

  function automatic logic [1:0] next_bresp();
    case (bresp_mode)
      1:       return (bresp_q.size() != 0) ? bresp_q.pop_front() : 2'b00;
      2:       return 2'b10;
      3:       return 2'($urandom_range(0, 3));
      default: return 2'b00;
    endcase
  endfunction

  // One clock: check outputs against the model, drive inputs, then record
  // the handshakes that the coming rising edge will perform.
  task automatic step();
    req_t r;
    @(negedge clk);
    check("wr_done", wr_done, exp_done_nxt);
    check("wr_err", wr_err, exp_err_nxt);
    if (wr_done) done_seen++;
    if (wr_err) err_seen++;
    exp_done_nxt = 1'b0;
    exp_err_nxt  = 1'b0;
    check("err_cnt", err_cnt, exp_err_cnt);
    check("err_resp", err_resp, exp_err_resp);
    check("req_ready", req_ready, exp_q.size() < 4);
    check("idle", idle, exp_q.size() == 0);
    if (axi_awvalid) begin
      check("aw_phase", {exp_q.size() != 0, aw_done}, 2'b10);
      if (exp_q.size() != 0) check("awaddr", axi_awaddr, exp_q[0].addr);
    end
    if (axi_wvalid) begin
      check("w_phase", {aw_done, w_done}, 2'b10);
      check("wlast", axi_wlast, 1'b1);
      if (exp_q.size() != 0) begin
        check("wdata", axi_wdata, exp_q[0].data);
        check("wstrb", axi_wstrb, exp_q[0].strb);
      end
    end
    if (axi_bready) check("b_phase", {aw_done, w_done}, 2'b11);

    if (req_q.size() != 0 && $urandom_range(1, 100) <= req_pct) begin
      req_valid = 1'b1;
      {req_addr, req_data, req_strb} = req_q[0];
    end else begin
      req_valid = 1'b0;
      {req_addr, req_data, req_strb} = rand_req();
    end
    axi_awready = ($urandom_range(1, 100) <= aw_pct);
    axi_wready  = ($urandom_range(1, 100) <= w_pct);
    if (w_done) begin
      if (!b_hold && $urandom_range(1, 100) <= b_pct) begin
        b_hold    = 1'b1;
        cur_bresp = next_bresp();
      end
      axi_bvalid = b_hold;
      axi_bresp  = cur_bresp;
    end else begin
      axi_bvalid = junk_b && ($urandom_range(0, 3) == 0);
      axi_bresp  = 2'b11;
    end

    if (req_valid && req_ready) begin
      exp_q.push_back(req_q.pop_front());
      acc_total++;
    end
    if (axi_awvalid && axi_awready) aw_done = 1'b1;
    if (axi_wvalid && axi_wready) w_done = 1'b1;
    if (axi_bvalid && axi_bready) begin
      if (exp_q.size() != 0) r = exp_q.pop_front();
      exp_done_nxt = 1'b1;
      exp_err_nxt  = axi_bresp[1];
      if (axi_bresp[1]) begin
        exp_err_resp = axi_bresp;
        if (exp_err_cnt != 8'hFF) exp_err_cnt = exp_err_cnt + 8'd1;
      end
      aw_done = 1'b0;
      w_done  = 1'b0;
      b_hold  = 1'b0;
    end
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while ((req_q.size() != 0 || exp_q.size() != 0) && k < limit) begin
      step();
      k++;
    end
    check("drain_done", (req_q.size() == 0 && exp_q.size() == 0), 1'b1);
    step();
  endtask

  task automatic clear_model();
    req_q.delete();
    exp_q.delete();
    bresp_q.delete();
    aw_done = 1'b0; w_done = 1'b0; b_hold = 1'b0;
    exp_done_nxt = 1'b0; exp_err_nxt = 1'b0;
    exp_err_cnt = 8'd0; exp_err_resp = 2'b00;
    req_valid = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0;
  endtask

  initial begin
    int base_done, base_err, base_acc;
    logic [31:0] held_addr;
    bit reached;

    // Reset
    #2 rst_n = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    check("rst_awvalid", axi_awvalid, 1'b0);
    check("rst_wvalid", axi_wvalid, 1'b0);
    check("rst_wlast", axi_wlast, 1'b0);
    check("rst_bready", axi_bready, 1'b0);
    check("rst_wr_done", wr_done, 1'b0);
    check("rst_wr_err", wr_err, 1'b0);
    check("rst_err_resp", err_resp, 2'b00);
    check("rst_err_cnt", err_cnt, 8'd0);
    check("rst_idle", idle, 1'b1);
    check("rst_req_ready", req_ready, 1'b1);
    rst_n = 1'b1;

    // Single store with exact cycle timing
    req_q.push_back('{32'h1000, {16{8'hA5}}, 16'hFFFF});
    step();
    step(); check("lat_t1_awvalid", axi_awvalid, 1'b0);
    step(); check("lat_t2_awvalid", axi_awvalid, 1'b1);
    check("lat_awaddr", axi_awaddr, 32'h1000);
    step(); check("single_wvalid", axi_wvalid, 1'b1);
    check("single_wdata", axi_wdata, {16{8'hA5}});
    step(); check("single_bready", axi_bready, 1'b1);
    step(); check("single_done", wr_done, 1'b1);
    check("single_idle", idle, 1'b1);
    drain(20);

    // Fill the queue with AW blocked
    aw_pct = 0;
    repeat (5) req_q.push_back(rand_req());
    repeat (12) step();
    check("fill_req_ready", req_ready, 1'b0);
    check("fill_held", req_q.size(), 1);
    check("fill_awvalid", axi_awvalid, 1'b1);
    aw_pct = 100;
    drain(100);

    // AW stall for 20 cycles
    aw_pct = 0;
    req_q.push_back(rand_req());
    reached = 1'b0;
    for (int i = 0; i < 10 && !reached; i++) begin
      step();
      reached = axi_awvalid;
    end
    check("stall_aw_up", reached, 1'b1);
    held_addr = axi_awaddr;
    repeat (20) step();
    check("stall_awvalid", axi_awvalid, 1'b1);
    check("stall_wvalid", axi_wvalid, 1'b0);
    check("stall_awaddr", axi_awaddr, held_addr);
    aw_pct = 100;
    step();
    step(); check("stall_w_after_aw", axi_wvalid, 1'b1);
    drain(50);

    // Error responses
    base_done = done_seen; base_err = err_seen;
    bresp_mode = 1;
    bresp_q.push_back(2'b10); bresp_q.push_back(2'b11); bresp_q.push_back(2'b01);
    repeat (3) req_q.push_back(rand_req());
    drain(100);
    check("errs_err_cnt", err_cnt, 8'd2);
    check("errs_err_resp", err_resp, 2'b11);
    check("errs_wr_err", err_seen - base_err, 2);
    check("errs_wr_done", done_seen - base_done, 3);
    check("errs_idle", idle, 1'b1);

    // Reset while the first of four entries sits in W
    bresp_mode = 0;
    w_pct = 0;
    repeat (4) req_q.push_back(rand_req());
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      step();
      reached = axi_wvalid && (exp_q.size() == 4);
    end
    check("midrst_reached", reached, 1'b1);
    #1 rst_n = 1'b0;
    #1 check("midrst_wvalid", axi_wvalid, 1'b0);
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    w_pct = 100;
    repeat (10) step();
    check("midrst_idle", idle, 1'b1);
    check("midrst_req_ready", req_ready, 1'b1);
    check("midrst_err_cnt", err_cnt, 8'd0);
    check("midrst_awvalid", axi_awvalid, 1'b0);

    // Error counter saturation
    base_err = err_seen;
    bresp_mode = 2;
    repeat (300) req_q.push_back(rand_req());
    drain(4000);
    check("sat_err_cnt", err_cnt, 8'hFF);
    check("sat_wr_err", err_seen - base_err, 300);

    // Random traffic with stray bvalid outside B
    base_done = done_seen; base_acc = acc_total;
    bresp_mode = 3;
    junk_b = 1'b1;
    for (int b = 0; b < 10; b++) begin
      req_pct = $urandom_range(20, 100);
      aw_pct  = $urandom_range(20, 100);
      w_pct   = $urandom_range(20, 100);
      b_pct   = $urandom_range(20, 100);
      repeat (20) req_q.push_back(rand_req());
      drain(3000);
    end
    check("rand_completions", done_seen - base_done, acc_total - base_acc);
    check("rand_idle", idle, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
